// File: rtl/shift_reg_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_mem_pkg
// Description : Shared types and constants for the shift-register memory
//               writer and reader.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_mem_pkg;

    // Default word width, shared with the writer-side combinational block
    localparam int WORD_W = 32;

    // Reader frame-collection states
    typedef enum logic [0:0] {
        RD_IDLE    = 1'b0,
        RD_COLLECT = 1'b1
    } rd_state_e;

endpackage : shift_reg_mem_pkg
`default_nettype wire

// File: rtl/shift_reg_mem_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_mem_out_buf
// Description : One-entry valid/ready holding register. A load while full
//               and not draining is refused and reported on o_drop.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_mem_out_buf
    import shift_reg_mem_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_drain;
    logic             w_room;

    // A held word leaves on a handshake; the slot is free if empty or draining
    assign w_drain = r_valid && i_ready;
    assign w_room  = !r_valid || i_ready;
    assign o_drop  = i_load && !w_room;

    // Holding register: load into a free slot, otherwise clear on drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load && w_room) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : shift_reg_mem_out_buf
`default_nettype wire

// File: rtl/shift_reg_mem_reader.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_mem_reader
// Description : Reassembles the MSB-first serial stream leaving the top of
//               the shift-register memory into signed words, presents them
//               through a one-entry valid/ready buffer and flags dropped or
//               truncated words.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_mem_reader
    import shift_reg_mem_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    serial_in,
    input  logic                    bit_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [CNT_W:0]          bit_count,
    output logic                    overflow,
    output logic                    frame_error,
    input  logic                    clear_flags
);

    typedef logic [CNT_W:0] cnt_t;
    localparam cnt_t c_cnt_one  = cnt_t'(1);
    localparam cnt_t c_cnt_last = cnt_t'(WIDTH - 1);

    rd_state_e        r_state;
    rd_state_e        w_state_next;
    logic [WIDTH-1:0] r_assembly;
    logic [WIDTH-1:0] w_assembly_next;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_first;
    cnt_t             r_bit_count;
    cnt_t             w_bit_count_next;
    logic             w_complete;
    logic             w_abort;
    logic             r_overflow;
    logic             r_frame_error;
    logic [WIDTH-1:0] w_buf_data;
    logic             w_drop;

    // A new frame starts with its first bit alone in the LSB
    assign w_first = WIDTH'(serial_in);

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shifted = serial_in;
        end else begin : g_shift_wn
            assign w_shifted = {r_assembly[WIDTH-2:0], serial_in};
        end
    endgenerate

    // State, assembly and bit-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RD_IDLE;
            r_assembly  <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_assembly  <= w_assembly_next;
            r_bit_count <= w_bit_count_next;
        end
    end

    // Next-state, collection and completion decode; start always restarts
    always_comb begin
        w_state_next     = r_state;
        w_assembly_next  = r_assembly;
        w_bit_count_next = r_bit_count;
        w_complete       = 1'b0;
        w_abort          = 1'b0;
        case (r_state)
            RD_IDLE: begin
                w_bit_count_next = '0;
                if (start) begin
                    w_assembly_next  = w_first;
                    w_bit_count_next = c_cnt_one;
                    if (WIDTH == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_next = RD_COLLECT;
                    end
                end
            end
            RD_COLLECT: begin
                if (start) begin
                    w_abort          = 1'b1;
                    w_assembly_next  = w_first;
                    w_bit_count_next = c_cnt_one;
                end else if (bit_valid) begin
                    w_assembly_next  = w_shifted;
                    w_bit_count_next = r_bit_count + c_cnt_one;
                    if (r_bit_count == c_cnt_last) begin
                        w_complete   = 1'b1;
                        w_state_next = RD_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = RD_IDLE;
            end
        endcase
    end

    shift_reg_mem_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_complete),
        .i_data  (w_assembly_next),
        .i_ready (out_ready),
        .o_data  (w_buf_data),
        .o_valid (out_valid),
        .o_drop  (w_drop)
    );

    // Sticky error flags; a set event in the same cycle beats clear_flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_abort) begin
                r_frame_error <= 1'b1;
            end else if (clear_flags) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign out_data    = w_buf_data;
    assign busy        = (r_state == RD_COLLECT);
    assign bit_count   = r_bit_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule : shift_reg_mem_reader
`default_nettype wire
